fpu_op_feeder: RTL and testbench

- Sits directly upstream of the FPU and also receives its results.
- Accepts operand pairs through a valid/ready handshake and buffers them in a small FIFO.
- Drives each pair onto the FPU operand inputs and holds it stable for a fixed settle window, because the FPU is multi-cycle and has no handshake.
- At the end of the window it captures the FPU result and status and presents them on a valid/ready result port.
- Operand format is the FPU's 32-bit layout: sign[31], exponent[30:20] (11 bits), mantissa[19:0] (20 bits). The block never interprets these fields.

---
 rtl/fpu_op_feeder.sv | 117 +++++++++++
 tb/tb_fpu_op_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_feeder.sv
// Operand feeder for a multi-cycle, handshake-less FPU: queues operand pairs,
// holds each on the FPU inputs for HOLD_CYCLES edges, then presents the result.
module fpu_op_feeder #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clock_100k,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  output logic        busy,
  output logic [7:0]  op_count
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, PRESENT} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [63:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [63:0]       head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  // Pop only when the FSM is idle; the popped pair goes straight to op_a/op_b.
  assign pop      = (state == IDLE) && !empty;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;

  // Storage has no reset; validity is tracked by count/pointers alone.
  always_ff @(posedge clock_100k) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: load operands, wait out the FPU settle window, present result.
  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            op_a     <= head[63:32];
            op_b     <= head[31:0];
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            res_data   <= fpu_data;
            res_status <= fpu_status;
            res_valid  <= 1'b1;
            state      <= PRESENT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        PRESENT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_feeder.sv
// Self-checking bench for fpu_op_feeder with an FPU stub that only settles
// after 15 stable cycles of its operands.
module tb_fpu_op_feeder;

  localparam int unsigned HOLD = 20;
  localparam int unsigned LAT  = HOLD + 1;
  localparam int unsigned GAP  = HOLD + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic        busy;
  logic [7:0]  op_count;

  int compared   = 0;
  int mismatched = 0;

  fpu_op_feeder #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(4)) dut (
    .clock_100k(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .fpu_data(fpu_data), .fpu_status(fpu_status),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_status(res_status), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // FPU stub: sum of operands, valid only once they have been stable 15 cycles.
  logic [63:0] last_ops = '0;
  int unsigned stab = 0;
  always @(posedge clk) begin
    if ({op_a, op_b} !== last_ops) begin
      last_ops <= {op_a, op_b};
      stab     <= 0;
    end else if (stab < 1000) begin
      stab <= stab + 1;
    end
  end
  assign fpu_data   = (stab >= 15) ? op_a + op_b : 'x;
  assign fpu_status = (stab >= 15) ? 4'b0001 : 'x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: FIFO order of accepted pairs, one result per result handshake.
  logic        mon_en = 1'b0;
  logic        wrap_phase = 1'b0;
  logic        ir_drop = 1'b0;
  logic [7:0]  mdl_cnt = '0;
  logic [63:0] sb_q[$];
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wrap_phase && !in_ready) ir_drop = 1'b1;
      if (in_valid && in_ready) sb_q.push_back({in_a, in_b});
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_underflow: actual=result required=no_result");
        end else begin
          logic [63:0] p;
          p = sb_q.pop_front();
          chk("sb_data", res_data, 32'(p[63:32] + p[31:0]));
          chk("sb_status", 32'(res_status), 32'h1);
          chk("sb_count", 32'(op_count), 32'(mdl_cnt));
        end
        mdl_cnt = mdl_cnt + 8'd1;
      end
    end
  end

  // One isolated operation with res_ready held high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sum, input logic [7:0] exp_cnt);
    int n;
    logic stable;
    res_ready = 1'b1;
    chk("op_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    tick();
    n = 1;
    chk("op_a_load", op_a, a);
    chk("op_b_load", op_b, b);
    stable = 1'b1;
    while (!res_valid && n < 100) begin
      tick();
      n++;
      if (op_a !== a || op_b !== b) stable = 1'b0;
    end
    chk("op_latency", 32'(n), 32'(LAT));
    chk("op_res_data", res_data, sum);
    chk("op_res_status", 32'(res_status), 32'h1);
    chk("op_hold_stable", 32'(stable), 32'h1);
    tick();
    chk("op_res_clear", 32'(res_valid), 32'h0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] bp_a[5];
  logic [31:0] bp_b[5];
  int          t_res[5];

  initial begin
    int n, k, cyc, sent;
    logic flag;
    logic [31:0] held;

    vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000002};
    vecs[1] = '{32'h40040000, 32'h40040000, 32'h80080000};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[3] = '{32'h12345678, 32'h0F0F0F0F, 32'h21436587};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    tick();
    tick();
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 4; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].sum, 8'(i + 1));

    // Asynchronous reset mid-cycle clears everything immediately.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_op_a", op_a, 32'h0);
    chk("arst_op_b", op_b, 32'h0);
    chk("arst_res_data", res_data, 32'h0);
    chk("arst_res_status", 32'(res_status), 32'h0);
    chk("arst_op_count", 32'(op_count), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'h1);

    // Backpressure: 5 pairs back to back, first popped, 4 fill the FIFO.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 32'(i * 16 + 3);
      bp_b[i] = 32'(i + 100);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = bp_a[i]; in_b = bp_b[i];
      tick();
    end
    chk("bp_full_ready", 32'(in_ready), 32'h0);
    in_a = 32'hDEAD0000; in_b = 32'h0000BEEF;
    repeat (3) tick();
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("bp_first_data", res_data, bp_a[0] + bp_b[0]);
    held = res_data;
    flag = 1'b1;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== held) flag = 1'b0;
    end
    chk("bp_held_50", 32'(flag), 32'h1);
    res_ready = 1'b1;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 500) begin
      if (res_valid) begin
        chk("bp_drain_data", res_data, bp_a[k] + bp_b[k]);
        t_res[k] = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    chk("bp_drain_num", 32'(k), 32'd5);
    for (int i = 1; i < 5; i++) chk("bp_spacing", 32'(t_res[i] - t_res[i-1]), 32'(GAP));
    chk("bp_op_count", 32'(op_count), 32'd5);
    chk("bp_idle", 32'(busy), 32'h0);

    // Reset in the middle of the hold window with two pairs still queued.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'(i + 7); in_b = 32'(i + 9);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_res_valid", 32'(res_valid), 32'h0);
    chk("mid_op_a", op_a, 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    @(negedge clk) rst = 1'b0;
    flag = 1'b0;
    repeat (40) begin
      tick();
      if (res_valid || busy) flag = 1'b1;
    end
    chk("mid_no_result", 32'(flag), 32'h0);
    run_op(32'h3F800000, 32'h00000005, 32'h3F800005, 8'd1);

    // Wrap: 256 ops from a fresh reset, one at a time.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_cnt = '0; sb_q.delete();
    mon_en = 1'b1; wrap_phase = 1'b1; ir_drop = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      tick();
      in_valid = 1'b0;
      n = 0;
      while ((busy || res_valid) && n < 100) begin tick(); n++; end
      if (n >= 100) flag = 1'b1;
      if (i == 254) chk("wrap_255", 32'(op_count), 32'd255);
    end
    chk("wrap_timeout", 32'(flag), 32'h0);
    chk("wrap_zero", 32'(op_count), 32'h0);
    chk("wrap_in_ready", 32'(ir_drop), 32'h0);
    wrap_phase = 1'b0;

    // Random traffic against the scoreboard.
    sent = 0; cyc = 0;
    while (sent < 60 && cyc < 8000) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_a      = $urandom;
      in_b      = $urandom;
      res_ready = $urandom_range(0, 1) == 1;
      #1;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; res_ready = 1'b1;
    n = 0;
    while ((busy || res_valid) && n < 1000) begin tick(); n++; end
    tick();
    chk("rnd_drained", 32'(busy), 32'h0);
    chk("rnd_sb_empty", 32'(sb_q.size()), 32'h0);
    chk("rnd_count", 32'(op_count), 32'(mdl_cnt));
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
